// File: rtl/cluster_dma_pkg.sv
// Shared types and sizing for the cluster DMA front end.
// Holds the address-width constants, the action/state enums and the issued-request descriptor.
package cluster_dma_pkg;

    localparam int SIZE        = 4;
    localparam int PROCSIZE    = 4;
    localparam int WORD_SIZE   = 8;
    localparam int PAGE_SIZE   = 2;
    localparam int PAGES_COUNT = SIZE - PAGE_SIZE;
    localparam int PROC_CNT    = 4;
    localparam int PROC_IDX_W  = $clog2(PROC_CNT);

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } dma_action_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [PROC_IDX_W-1:0] proc;
        dma_action_t           action;
        logic [SIZE-1:0]       ptr;
        logic [PROCSIZE-1:0]   copy_start;
        logic [PROCSIZE-1:0]   copy_length;
    } dma_req_t;

    // Successor index that wraps for any processor count, not just powers of two.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of pending at or after base, wrapping.
// Scanned from the farthest offset down so the nearest pending index is the one left standing.
module rr_arbiter #(
    parameter int  N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  pending,
    input  logic [IW-1:0] base,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [IW-1:0] cand;

    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = IW'((int'(base) + i) % N);
            if (pending[cand]) begin
                grant_idx   = cand;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_request_arbiter.sv
// DMA front end: turns per-processor request toggles into latched descriptors, issues them
// round-robin over valid/ready, then reports completion by toggling ack and returning a page pointer.
module dma_request_arbiter #(
    parameter int  PROC_CNT    = 4,
    parameter int  SIZE        = cluster_dma_pkg::SIZE,
    parameter int  PROCSIZE    = cluster_dma_pkg::PROCSIZE,
    parameter int  PAGES_COUNT = cluster_dma_pkg::PAGES_COUNT,
    localparam int IDX_W       = $clog2(PROC_CNT)
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [PROC_CNT-1:0]                  trigger,
    input  logic [PROC_CNT-1:0]                  action,
    input  logic [PROC_CNT-1:0][SIZE-1:0]        ptr,
    input  logic [PROC_CNT-1:0][PROCSIZE-1:0]    copy_start,
    input  logic [PROC_CNT-1:0][PROCSIZE-1:0]    copy_length,
    output logic [PROC_CNT-1:0]                  ack,
    output logic [PROC_CNT-1:0][PAGES_COUNT-1:0] ptr_out,
    output logic [PROC_CNT-1:0]                  overflow,
    output logic                                 req_valid,
    input  logic                                 req_ready,
    output logic [IDX_W-1:0]                     req_proc,
    output logic                                 req_action,
    output logic [SIZE-1:0]                      req_ptr,
    output logic [PROCSIZE-1:0]                  req_copy_start,
    output logic [PROCSIZE-1:0]                  req_copy_length,
    input  logic                                 dma_done,
    input  logic [PAGES_COUNT-1:0]               dma_done_ptr
);

    import cluster_dma_pkg::dma_action_t;
    import cluster_dma_pkg::WRITE;
    import cluster_dma_pkg::arb_state_t;
    import cluster_dma_pkg::IDLE;
    import cluster_dma_pkg::ISSUE;
    import cluster_dma_pkg::BUSY;
    import cluster_dma_pkg::wrap_inc;

    arb_state_t state;
    arb_state_t state_next;

    logic [PROC_CNT-1:0]               last_trigger;
    logic [PROC_CNT-1:0]               toggled;
    logic [PROC_CNT-1:0]               pending;
    logic [PROC_CNT-1:0]               complete;
    logic [PROC_CNT-1:0]               slot_action;
    logic [PROC_CNT-1:0][SIZE-1:0]     slot_ptr;
    logic [PROC_CNT-1:0][PROCSIZE-1:0] slot_start;
    logic [PROC_CNT-1:0][PROCSIZE-1:0] slot_len;

    logic [IDX_W-1:0] rr_next;
    logic [IDX_W-1:0] rr_next_d;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             load_req;
    logic             req_valid_d;
    logic             store_ptr;

    assign toggled = trigger ^ last_trigger;

    rr_arbiter #(
        .N (PROC_CNT)
    ) u_rr_arbiter (
        .pending     (pending),
        .base        (rr_next),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // A slot completing on this edge counts as free, so a toggle landing with the done pulse is kept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_trigger <= '0;
            pending      <= '0;
            ack          <= '0;
            overflow     <= '0;
            slot_action  <= '0;
            slot_ptr     <= '0;
            slot_start   <= '0;
            slot_len     <= '0;
        end else begin
            for (int p = 0; p < PROC_CNT; p++) begin
                if (complete[p]) begin
                    pending[p] <= 1'b0;
                    ack[p]     <= ~ack[p];
                end
                if (toggled[p]) begin
                    last_trigger[p] <= trigger[p];
                    if (!pending[p] || complete[p]) begin
                        pending[p]     <= 1'b1;
                        slot_action[p] <= action[p];
                        slot_ptr[p]    <= ptr[p];
                        slot_start[p]  <= copy_start[p];
                        slot_len[p]    <= copy_length[p];
                    end else begin
                        overflow[p] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Zero-length requests complete straight from IDLE and still move the round-robin pointer on.
    always_comb begin
        state_next  = state;
        req_valid_d = req_valid;
        rr_next_d   = rr_next;
        load_req    = 1'b0;
        store_ptr   = 1'b0;
        complete    = '0;
        unique case (state)
            IDLE: begin
                if (grant_valid) begin
                    if (slot_len[grant_idx] == '0) begin
                        complete[grant_idx] = 1'b1;
                        rr_next_d           = IDX_W'(wrap_inc(32'(grant_idx), PROC_CNT));
                    end else begin
                        load_req    = 1'b1;
                        req_valid_d = 1'b1;
                        state_next  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (req_ready) begin
                    req_valid_d = 1'b0;
                    state_next  = BUSY;
                end
            end
            BUSY: begin
                if (dma_done) begin
                    complete[req_proc] = 1'b1;
                    store_ptr          = (dma_action_t'(req_action) == WRITE);
                    rr_next_d          = IDX_W'(wrap_inc(32'(req_proc), PROC_CNT));
                    state_next         = IDLE;
                end
            end
            default: begin
                state_next  = IDLE;
                req_valid_d = 1'b0;
            end
        endcase
    end

    // Downstream descriptor is loaded once per grant and held untouched until the handshake.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_next         <= '0;
            req_valid       <= 1'b0;
            req_proc        <= '0;
            req_action      <= 1'b0;
            req_ptr         <= '0;
            req_copy_start  <= '0;
            req_copy_length <= '0;
            ptr_out         <= '0;
        end else begin
            rr_next   <= rr_next_d;
            req_valid <= req_valid_d;
            if (load_req) begin
                req_proc        <= grant_idx;
                req_action      <= slot_action[grant_idx];
                req_ptr         <= slot_ptr[grant_idx];
                req_copy_start  <= slot_start[grant_idx];
                req_copy_length <= slot_len[grant_idx];
            end
            if (store_ptr) begin
                ptr_out[req_proc] <= dma_done_ptr;
            end
        end
    end

endmodule

// File: tb/tb_dma_request_arbiter.sv
// Directed bench for dma_request_arbiter: single write, round-robin order, back-pressure,
// overflow, zero-length and reset-abort sequences with hand-worked expected values.
module tb_dma_request_arbiter;

    logic             clock;
    logic             reset_n;
    logic [3:0]       trigger;
    logic [3:0]       action;
    logic [3:0][3:0]  ptr;
    logic [3:0][3:0]  copy_start;
    logic [3:0][3:0]  copy_length;
    logic [3:0]       ack;
    logic [3:0][1:0]  ptr_out;
    logic [3:0]       overflow;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_proc;
    logic             req_action;
    logic [3:0]       req_ptr;
    logic [3:0]       req_copy_start;
    logic [3:0]       req_copy_length;
    logic             dma_done;
    logic [1:0]       dma_done_ptr;

    int vectors;
    int miscompares;

    dma_request_arbiter dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .trigger         (trigger),
        .action          (action),
        .ptr             (ptr),
        .copy_start      (copy_start),
        .copy_length     (copy_length),
        .ack             (ack),
        .ptr_out         (ptr_out),
        .overflow        (overflow),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_proc        (req_proc),
        .req_action      (req_action),
        .req_ptr         (req_ptr),
        .req_copy_start  (req_copy_start),
        .req_copy_length (req_copy_length),
        .dma_done        (dma_done),
        .dma_done_ptr    (dma_done_ptr)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input int p, input logic act, input logic [3:0] p_ptr,
                                  input logic [3:0] start, input logic [3:0] len);
        action[p]      = act;
        ptr[p]         = p_ptr;
        copy_start[p]  = start;
        copy_length[p] = len;
        trigger[p]     = ~trigger[p];
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset_n      = 1'b0;
        trigger      = '0;
        action       = '0;
        ptr          = '0;
        copy_start   = '0;
        copy_length  = '0;
        req_ready    = 1'b0;
        dma_done     = 1'b0;
        dma_done_ptr = '0;

        // reset held three cycles
        repeat (3) tick();
        check_output("rst_ack", 32'(ack), 'h0);
        check_output("rst_ptr_out", 32'(ptr_out), 'h0);
        check_output("rst_overflow", 32'(overflow), 'h0);
        check_output("rst_req_valid", 32'(req_valid), 'h0);
        check_output("rst_req_proc", 32'(req_proc), 'h0);
        reset_n = 1'b1;
        repeat (2) tick();
        check_output("post_rst_ack", 32'(ack), 'h0);
        check_output("post_rst_valid", 32'(req_valid), 'h0);

        // single WRITE from p1 with allocate pointer
        apply_stimulus(1, 1'b1, 4'h0, 4'h2, 4'h3);
        tick();
        check_output("wr_not_yet_valid", 32'(req_valid), 'h0);
        tick();
        check_output("wr_valid", 32'(req_valid), 'h1);
        check_output("wr_proc", 32'(req_proc), 'h1);
        check_output("wr_action", 32'(req_action), 'h1);
        check_output("wr_ptr", 32'(req_ptr), 'h0);
        check_output("wr_start", 32'(req_copy_start), 'h2);
        check_output("wr_len", 32'(req_copy_length), 'h3);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check_output("wr_accepted", 32'(req_valid), 'h0);
        check_output("wr_no_ack_yet", 32'(ack), 'h0);
        dma_done     = 1'b1;
        dma_done_ptr = 2'd2;
        tick();
        dma_done = 1'b0;
        check_output("wr_ack", 32'(ack), 'h2);
        check_output("wr_ptr_out", 32'(ptr_out), 'h08);

        // p2 READ moves rr_next to 3 and leaves ptr_out alone
        apply_stimulus(2, 1'b0, 4'hC, 4'h1, 4'h2);
        repeat (2) tick();
        check_output("rd_proc", 32'(req_proc), 'h2);
        check_output("rd_action", 32'(req_action), 'h0);
        check_output("rd_ptr", 32'(req_ptr), 'hC);
        req_ready = 1'b1;
        tick();
        req_ready    = 1'b0;
        dma_done     = 1'b1;
        dma_done_ptr = 2'd3;
        tick();
        dma_done = 1'b0;
        check_output("rd_ack", 32'(ack), 'h6);
        check_output("rd_ptr_out_kept", 32'(ptr_out), 'h08);

        // round robin: p0, p2, p3 together with rr_next=3 -> order 3, 0, 2
        apply_stimulus(0, 1'b1, 4'h5, 4'h0, 4'h1);
        apply_stimulus(2, 1'b0, 4'h8, 4'h3, 4'h4);
        apply_stimulus(3, 1'b1, 4'h1, 4'h7, 4'h5);
        tick();
        ptr[0]         = 4'hF;
        copy_length[3] = 4'h9;
        tick();
        check_output("rr1_proc", 32'(req_proc), 'h3);
        check_output("rr1_ptr", 32'(req_ptr), 'h1);
        check_output("rr1_start", 32'(req_copy_start), 'h7);
        check_output("rr1_len", 32'(req_copy_length), 'h5);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        tick();
        check_output("rr1_ack_waits", 32'(ack), 'h6);
        dma_done     = 1'b1;
        dma_done_ptr = 2'd1;
        tick();
        dma_done = 1'b0;
        check_output("rr1_ack", 32'(ack), 'hE);
        check_output("rr1_ptr_out", 32'(ptr_out), 'h48);
        tick();
        check_output("rr2_proc", 32'(req_proc), 'h0);
        check_output("rr2_ptr_sampled", 32'(req_ptr), 'h5);
        check_output("rr2_action", 32'(req_action), 'h1);
        req_ready = 1'b1;
        tick();
        req_ready    = 1'b0;
        dma_done     = 1'b1;
        dma_done_ptr = 2'd3;
        tick();
        dma_done = 1'b0;
        check_output("rr2_ack", 32'(ack), 'hF);
        check_output("rr2_ptr_out", 32'(ptr_out), 'h4B);
        tick();
        check_output("rr3_proc", 32'(req_proc), 'h2);
        check_output("rr3_ptr", 32'(req_ptr), 'h8);
        check_output("rr3_len", 32'(req_copy_length), 'h4);
        req_ready = 1'b1;
        tick();
        req_ready    = 1'b0;
        dma_done     = 1'b1;
        dma_done_ptr = 2'd0;
        tick();
        dma_done = 1'b0;
        check_output("rr3_ack", 32'(ack), 'hB);
        check_output("rr3_ptr_out", 32'(ptr_out), 'h4B);

        // back-pressure on p3
        apply_stimulus(3, 1'b1, 4'h6, 4'h2, 4'h7);
        repeat (2) tick();
        check_output("bp_valid", 32'(req_valid), 'h1);
        check_output("bp_proc", 32'(req_proc), 'h3);
        for (int i = 0; i < 5; i++) begin
            ptr[3] = 4'(i);
            tick();
            check_output("bp_hold_valid", 32'(req_valid), 'h1);
            check_output("bp_hold_ptr", 32'(req_ptr), 'h6);
            check_output("bp_hold_len", 32'(req_copy_length), 'h7);
        end
        req_ready = 1'b1;
        tick();
        check_output("bp_accepted", 32'(req_valid), 'h0);
        tick();
        req_ready = 1'b0;
        check_output("bp_single_issue", 32'(req_valid), 'h0);
        dma_done     = 1'b1;
        dma_done_ptr = 2'd2;
        tick();
        dma_done = 1'b0;
        check_output("bp_ack", 32'(ack), 'h3);
        check_output("bp_ptr_out", 32'(ptr_out), 'h8B);

        // done pulse while idle is ignored
        dma_done     = 1'b1;
        dma_done_ptr = 2'd3;
        tick();
        dma_done = 1'b0;
        check_output("idle_done_ack", 32'(ack), 'h3);
        check_output("idle_done_ptr_out", 32'(ptr_out), 'h8B);

        // overflow on p0, then a toggle coinciding with done is accepted
        apply_stimulus(0, 1'b1, 4'h9, 4'h4, 4'h2);
        repeat (2) tick();
        check_output("ov_valid", 32'(req_valid), 'h1);
        check_output("ov_proc", 32'(req_proc), 'h0);
        check_output("ov_ptr", 32'(req_ptr), 'h9);
        trigger[0] = ~trigger[0];
        req_ready  = 1'b1;
        tick();
        req_ready = 1'b0;
        check_output("ov_flag", 32'(overflow), 'h1);
        apply_stimulus(0, 1'b0, 4'hA, 4'h5, 4'h3);
        dma_done     = 1'b1;
        dma_done_ptr = 2'd1;
        tick();
        dma_done = 1'b0;
        check_output("ov_ack", 32'(ack), 'h2);
        check_output("ov_ptr_out", 32'(ptr_out), 'h89);
        check_output("ov_flag_sticky", 32'(overflow), 'h1);
        tick();
        check_output("ov2_valid", 32'(req_valid), 'h1);
        check_output("ov2_proc", 32'(req_proc), 'h0);
        check_output("ov2_action", 32'(req_action), 'h0);
        check_output("ov2_ptr", 32'(req_ptr), 'hA);
        check_output("ov2_len", 32'(req_copy_length), 'h3);
        req_ready = 1'b1;
        tick();
        req_ready    = 1'b0;
        dma_done     = 1'b1;
        dma_done_ptr = 2'd2;
        tick();
        dma_done = 1'b0;
        check_output("ov2_ack", 32'(ack), 'h3);
        check_output("ov2_ptr_out", 32'(ptr_out), 'h89);
        tick();
        check_output("ov_no_extra_issue", 32'(req_valid), 'h0);

        // zero-length READ on p2 acks without any downstream issue
        apply_stimulus(2, 1'b0, 4'h3, 4'h0, 4'h0);
        tick();
        check_output("zl_no_ack_yet", 32'(ack), 'h3);
        tick();
        check_output("zl_ack", 32'(ack), 'h7);
        check_output("zl_no_valid", 32'(req_valid), 'h0);
        tick();
        check_output("zl_still_no_valid", 32'(req_valid), 'h0);

        // asynchronous reset while BUSY aborts without ack
        apply_stimulus(1, 1'b1, 4'h0, 4'h1, 4'h2);
        repeat (2) tick();
        check_output("ar_valid", 32'(req_valid), 'h1);
        check_output("ar_proc", 32'(req_proc), 'h1);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check_output("ar_busy", 32'(req_valid), 'h0);
        #3 reset_n = 1'b0;
        #1;
        check_output("ar_ack_cleared", 32'(ack), 'h0);
        check_output("ar_ptr_out_cleared", 32'(ptr_out), 'h0);
        check_output("ar_overflow_cleared", 32'(overflow), 'h0);
        check_output("ar_valid_cleared", 32'(req_valid), 'h0);
        trigger  = '0;
        dma_done = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        dma_done = 1'b0;
        check_output("ar_no_ack", 32'(ack), 'h0);
        check_output("ar_no_valid", 32'(req_valid), 'h0);
        apply_stimulus(3, 1'b1, 4'h2, 4'h0, 4'h1);
        repeat (2) tick();
        check_output("ar_restart_valid", 32'(req_valid), 'h1);
        check_output("ar_restart_proc", 32'(req_proc), 'h3);
        check_output("ar_restart_ack", 32'(ack), 'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
